onehot_codec: RTL and testbench

Parametrised, handshaked binary/one-hot converter with per-item error detection and a 2-entry output buffer. It replaces ad-hoc combinational binary-to-one-hot decoders wherever a converted select vector crosses a pipeline boundary. It runs in encode (binary→one-hot) or decode (one-hot→binary) mode, selected per item, and supports one-hot widths that are not powers of two. Malformed inputs are flagged and counted.

---
 rtl/onehot_codec.sv | 124 ++++++++++++
 tb/tb_onehot_codec.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_codec.sv
// rtl/onehot_codec.sv - handshaked binary/one-hot converter with error flagging and 2-entry output buffer
module onehot_codec #(
   parameter int BIN_W     = 4,
   parameter int ONE_HOT_W = 1 << BIN_W,
   parameter int CNT_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 mode_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [BIN_W-1:0]     bin_i,
   input  logic [ONE_HOT_W-1:0] one_hot_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 mode_o,
   output logic [ONE_HOT_W-1:0] one_hot_o,
   output logic [BIN_W-1:0]     bin_o,
   output logic                 err_o,
   input  logic                 clr_cnt_i,
   output logic [CNT_W-1:0]     err_cnt_o
);

   // Entry layout, MSB first: mode, err, bin, one_hot.
   localparam int               ENT_W    = 2 + BIN_W + ONE_HOT_W;
   localparam logic [BIN_W:0]   OH_LIMIT = (BIN_W + 1)'(ONE_HOT_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [ENT_W-1:0]     fifo_mem [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           occ;
   logic                 push;
   logic                 pop;
   logic [ONE_HOT_W-1:0] enc_oh;
   logic                 enc_err;
   logic [BIN_W-1:0]     dec_bin;
   logic                 dec_found;
   logic                 dec_multi;
   logic                 dec_err;
   logic                 new_err;
   logic [ENT_W-1:0]     new_entry;
   logic [ENT_W-1:0]     head_entry;
   logic [CNT_W-1:0]     err_cnt;

   // Ready comes from occupancy and reset only, never from the handshake inputs.
   assign in_ready_o  = (occ != 2'd2) & ~rst_i;
   assign out_valid_o = (occ != 2'd0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   // Encode: out-of-range codes match no bit position, so the vector falls to zero on error.
   always_comb begin
      enc_oh  = '0;
      enc_err = ({1'b0, bin_i} >= OH_LIMIT);
      for (int i = 0; i < ONE_HOT_W; i++) begin
         enc_oh[i] = (bin_i == BIN_W'(i));
      end
   end

   // Decode: report the lowest set bit; a second set bit or no set bit marks the item malformed.
   always_comb begin
      dec_bin   = '0;
      dec_found = 1'b0;
      dec_multi = 1'b0;
      for (int i = 0; i < ONE_HOT_W; i++) begin
         if (one_hot_i[i]) begin
            if (dec_found) begin
               dec_multi = 1'b1;
            end else begin
               dec_bin   = BIN_W'(i);
               dec_found = 1'b1;
            end
         end
      end
   end

   assign dec_err   = ~dec_found | dec_multi;
   assign new_err   = mode_i ? dec_err : enc_err;
   assign new_entry = mode_i ? {1'b1, dec_err, dec_bin, {ONE_HOT_W{1'b0}}}
                             : {1'b0, enc_err, {BIN_W{1'b0}}, enc_oh};

   // Two-entry FIFO: write at wr_ptr on acceptance, advance rd_ptr on consumption.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ         <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= new_entry;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Saturating malformed-item counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_cnt_i) begin
         err_cnt <= '0;
      end else if (push && new_err && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   // Outputs read as zero whenever the buffer is empty.
   assign head_entry = out_valid_o ? fifo_mem[rd_ptr] : '0;
   assign mode_o     = head_entry[ENT_W-1];
   assign err_o      = head_entry[ENT_W-2];
   assign bin_o      = head_entry[BIN_W+ONE_HOT_W-1:ONE_HOT_W];
   assign one_hot_o  = head_entry[ONE_HOT_W-1:0];
   assign err_cnt_o  = err_cnt;

endmodule

// File: tb/tb_onehot_codec.sv
// tb/tb_onehot_codec.sv - scoreboard bench for onehot_codec (16-wide and 12-wide instances)
module tb_onehot_codec;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic        in_valid;
   logic [3:0]  bin;
   logic [15:0] oh;
   logic        out_ready;
   logic        clr_cnt;

   logic        a_in_ready, a_out_valid, a_mode, a_err;
   logic [15:0] a_oh;
   logic [3:0]  a_bin;
   logic [3:0]  a_cnt;
   logic        b_in_ready, b_out_valid, b_mode, b_err;
   logic [11:0] b_oh;
   logic [3:0]  b_bin;
   logic [3:0]  b_cnt;

   logic [21:0] qa[$];
   logic [17:0] qb[$];
   int          nchk = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   onehot_codec #(.BIN_W(4), .ONE_HOT_W(16), .CNT_W(4)) u_a (
      .clk_i(clk), .rst_i(rst), .mode_i(mode), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
      .bin_i(bin), .one_hot_i(oh), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
      .mode_o(a_mode), .one_hot_o(a_oh), .bin_o(a_bin), .err_o(a_err),
      .clr_cnt_i(clr_cnt), .err_cnt_o(a_cnt)
   );

   onehot_codec #(.BIN_W(4), .ONE_HOT_W(12), .CNT_W(4)) u_b (
      .clk_i(clk), .rst_i(rst), .mode_i(mode), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
      .bin_i(bin), .one_hot_i(oh[11:0]), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
      .mode_o(b_mode), .one_hot_o(b_oh), .bin_o(b_bin), .err_o(b_err),
      .clr_cnt_i(clr_cnt), .err_cnt_o(b_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Present one item from a negedge, wait for acceptance, push expectations, return at the following negedge.
   task automatic send(input logic m, input logic [3:0] b, input logic [15:0] o,
                       input logic [15:0] ea_oh, input logic [3:0] ea_bin, input logic ea_err,
                       input logic [11:0] eb_oh, input logic [3:0] eb_bin, input logic eb_err);
      int t = 0;
      mode     = m;
      bin      = b;
      oh       = o;
      in_valid = 1'b1;
      while (!a_in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!a_in_ready) begin
         nchk++;
         nfail++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 at %0t", $time);
         in_valid = 1'b0;
         return;
      end
      qa.push_back({m, ea_err, ea_bin, ea_oh});
      qb.push_back({m, eb_err, eb_bin, eb_oh});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on each consumption and checks that a stalled head holds still.
   initial begin : monitor
      logic        a_stall;
      logic [21:0] a_held;
      logic [21:0] ea;
      logic [17:0] eb;
      a_stall = 1'b0;
      a_held  = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            qa.delete();
            qb.delete();
            a_stall = 1'b0;
         end else begin
            if (a_stall && a_out_valid) chk("a_hold", {a_mode, a_err, a_bin, a_oh}, a_held);
            if (a_out_valid && out_ready) begin
               if (qa.size() == 0) begin
                  nchk++;
                  nfail++;
                  $display("FAIL a_unexpected: got item 0x%0h, expected none", {a_mode, a_err, a_bin, a_oh});
               end else begin
                  ea = qa.pop_front();
                  chk("a_item", {a_mode, a_err, a_bin, a_oh}, ea);
               end
            end
            if (b_out_valid && out_ready) begin
               if (qb.size() == 0) begin
                  nchk++;
                  nfail++;
                  $display("FAIL b_unexpected: got item 0x%0h, expected none", {b_mode, b_err, b_bin, b_oh});
               end else begin
                  eb = qb.pop_front();
                  chk("b_item", {b_mode, b_err, b_bin, b_oh}, eb);
               end
            end
            a_stall = a_out_valid && !out_ready;
            a_held  = {a_mode, a_err, a_bin, a_oh};
         end
      end
   end

   // Directed stimulus phases.
   initial begin
      rst = 1'b1; mode = 1'b0; in_valid = 1'b0; bin = '0; oh = '0; out_ready = 1'b0; clr_cnt = 1'b0;
      cycles(2);
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_outputs", {a_mode, a_err, a_bin, a_oh}, 0);
      chk("rst_cnt", a_cnt, 0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", a_in_ready, 1);

      // Encode sweep, back-to-back with downstream always ready.
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send(1'b0, 4'(i), 16'h0, 16'h1 << i, 4'h0, 1'b0,
              (i < 12) ? (12'h1 << i) : 12'h0, 4'h0, (i >= 12));
         if (i == 0) chk("latency_valid", a_out_valid, 1);
         chk("sweep_ready", a_in_ready, 1);
      end
      in_valid = 1'b0;
      cycles(2);
      chk("sweep_cnt_a", a_cnt, 0);
      chk("sweep_cnt_b", b_cnt, 4);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      chk("clr_cnt_b", b_cnt, 0);

      // Decode, including malformed vectors; bin_i carries junk that must be ignored.
      send(1'b1, 4'hA, 16'h0000, 16'h0, 4'd0,  1'b1, 12'h0, 4'd0, 1'b1);
      send(1'b1, 4'hA, 16'h0100, 16'h0, 4'd8,  1'b0, 12'h0, 4'd8, 1'b0);
      send(1'b1, 4'hA, 16'h0110, 16'h0, 4'd4,  1'b1, 12'h0, 4'd4, 1'b1);
      send(1'b1, 4'hA, 16'h8000, 16'h0, 4'd15, 1'b0, 12'h0, 4'd0, 1'b1);
      in_valid = 1'b0;
      cycles(2);
      chk("dec_cnt_a", a_cnt, 2);
      chk("dec_cnt_b", b_cnt, 3);
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;

      // Range edge for the 12-wide instance; one_hot_i carries junk that must be ignored.
      send(1'b0, 4'd11, 16'hFFFF, 16'h0800, 4'd0, 1'b0, 12'h800, 4'd0, 1'b0);
      send(1'b0, 4'd12, 16'hFFFF, 16'h1000, 4'd0, 1'b0, 12'h000, 4'd0, 1'b1);
      send(1'b0, 4'd15, 16'hFFFF, 16'h8000, 4'd0, 1'b0, 12'h000, 4'd0, 1'b1);
      in_valid = 1'b0;
      cycles(2);
      chk("np2_cnt_a", a_cnt, 0);
      chk("np2_cnt_b", b_cnt, 2);

      // Backpressure: A and B fill the buffer, C waits until the drain starts.
      out_ready = 1'b0;
      send(1'b0, 4'd3,  16'h0,    16'h0008, 4'd0, 1'b0, 12'h008, 4'd0, 1'b0);
      send(1'b1, 4'd0,  16'h0020, 16'h0,    4'd5, 1'b0, 12'h000, 4'd5, 1'b0);
      fork
         send(1'b0, 4'd14, 16'h0, 16'h4000, 4'd0, 1'b0, 12'h000, 4'd0, 1'b1);
         begin
            #1;
            chk("full_ready", a_in_ready, 0);
            chk("full_head", {a_mode, a_err, a_bin, a_oh}, {1'b0, 1'b0, 4'd0, 16'h0008});
            repeat (3) begin
               @(negedge clk);
               #1;
               chk("full_ready_hold", a_in_ready, 0);
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      in_valid = 1'b0;
      cycles(6);
      chk("bp_drain_a", qa.size(), 0);
      chk("bp_drain_b", qb.size(), 0);

      // Counter saturation, then clear racing a malformed acceptance.
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 4'h0, 16'h0000, 16'h0, 4'd0, 1'b1, 12'h0, 4'd0, 1'b1);
         if (i == 13) chk("cnt_14", a_cnt, 14);
      end
      chk("cnt_sat_a", a_cnt, 15);
      chk("cnt_sat_b", b_cnt, 15);
      clr_cnt = 1'b1;
      send(1'b1, 4'h0, 16'h0000, 16'h0, 4'd0, 1'b1, 12'h0, 4'd0, 1'b1);
      clr_cnt  = 1'b0;
      in_valid = 1'b0;
      chk("clr_prio_a", a_cnt, 0);
      chk("clr_prio_b", b_cnt, 0);
      cycles(3);

      // Reset with two items buffered.
      out_ready = 1'b0;
      send(1'b1, 4'h0, 16'h0000, 16'h0,    4'd0, 1'b1, 12'h000, 4'd0, 1'b1);
      send(1'b0, 4'd2, 16'h0,    16'h0004, 4'd0, 1'b0, 12'h004, 4'd0, 1'b0);
      in_valid = 1'b0;
      chk("pre_rst_ready", a_in_ready, 0);
      chk("pre_rst_valid", a_out_valid, 1);
      chk("pre_rst_cnt", a_cnt, 1);
      rst = 1'b1;
      #1;
      chk("in_rst_ready", a_in_ready, 0);
      @(negedge clk);
      chk("in_rst_valid", a_out_valid, 0);
      chk("in_rst_cnt", a_cnt, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("post_rst_ready", a_in_ready, 1);
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_no_stale", a_out_valid | b_out_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
